// File: rtl/pipe_fetch.sv
// IF stage and IF/ID pipeline register of the 5-stage MIPS core with a request/ready instruction port.
// Optional macro IF_BUBBLE_CNT_EN adds a bubble_cnt output counting memory-wait bubbles.
module pipe_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] ra,
  input  logic        wpcir,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
`ifdef IF_BUBBLE_CNT_EN
  output logic [31:0] bubble_cnt,
`endif
  output logic [31:0] dpc4,
  output logic [31:0] inst
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] dpc4_q, dpc4_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        redir_valid_q, redir_valid_d;
`ifdef IF_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
`endif

  logic        deliver;
  logic        redirect;
  logic [31:0] word;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    pc_d          = pc_q;
    dpc4_d        = dpc4_q;
    inst_d        = inst_q;
    buf_d         = buf_q;
    redir_pc_d    = redir_pc_q;
    redir_valid_d = redir_valid_q;
`ifdef IF_BUBBLE_CNT_EN
    bubble_cnt_d  = bubble_cnt_q;
`endif

    pc_plus4 = pc_q + 32'd4;
    deliver  = wpcir & (((state_q == S_FETCH) & imem_ready) | (state_q == S_HOLD));
    word     = (state_q == S_HOLD) ? buf_q : imem_rdata;
    redirect = wpcir & (pcsource != 2'b00);

    unique case (pcsource)
      2'b01:   target = bpc;
      2'b10:   target = ra;
      2'b11:   target = jpc;
      default: target = pc_plus4;
    endcase

    // IF/ID register: freeze on stall, bubble when the memory has not answered.
    if (wpcir) begin
      if (deliver) begin
        inst_d = word;
        dpc4_d = pc_plus4;
      end else begin
        inst_d = 32'h0;
`ifdef IF_BUBBLE_CNT_EN
        bubble_cnt_d = bubble_cnt_q + 32'd1;
`endif
      end
    end

    // A redirect seen while the delay-slot fetch is still pending is parked in redir_pc.
    if (deliver) begin
      if (redirect) begin
        pc_d          = target;
        redir_valid_d = 1'b0;
      end else if (redir_valid_q) begin
        pc_d          = redir_pc_q;
        redir_valid_d = 1'b0;
      end else begin
        pc_d = pc_plus4;
      end
    end else if (redirect) begin
      redir_pc_d    = target;
      redir_valid_d = 1'b1;
    end

    unique case (state_q)
      S_FETCH: begin
        if (imem_ready && !wpcir) begin
          state_d = S_HOLD;
          buf_d   = imem_rdata;
        end
      end
      S_HOLD: begin
        if (wpcir) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      // NOTE: sequential state uses non-blocking assignments; all state, including the buffer, is reset.
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      dpc4_q        <= 32'h0;
      inst_q        <= 32'h0;
      buf_q         <= 32'h0;
      redir_pc_q    <= 32'h0;
      redir_valid_q <= 1'b0;
`ifdef IF_BUBBLE_CNT_EN
      bubble_cnt_q  <= 32'h0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      dpc4_q        <= dpc4_d;
      inst_q        <= inst_d;
      buf_q         <= buf_d;
      redir_pc_q    <= redir_pc_d;
      redir_valid_q <= redir_valid_d;
`ifdef IF_BUBBLE_CNT_EN
      bubble_cnt_q  <= bubble_cnt_d;
`endif
    end
  end

  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign dpc4      = dpc4_q;
  assign inst      = inst_q;
`ifdef IF_BUBBLE_CNT_EN
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_fetch.sv
// Directed bench for pipe_fetch: vector table for the pipeline walk, hand sequences for async reset.
// The memory model answers each address with addr ^ 32'hA5A5_0000.
module tb_pipe_fetch;

  logic        clock;
  logic        resetn;
  logic [1:0]  pcsource;
  logic [31:0] bpc, jpc, ra;
  logic        wpcir;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc, dpc4, inst;
`ifdef IF_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  pipe_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .jpc        (jpc),
    .ra         (ra),
    .wpcir      (wpcir),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .pc         (pc),
`ifdef IF_BUBBLE_CNT_EN
    .bubble_cnt (bubble_cnt),
`endif
    .dpc4       (dpc4),
    .inst       (inst)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  typedef struct {
    logic        wpcir;
    logic [1:0]  ps;
    logic [31:0] tgt;
    logic        ready;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_dpc4;
    logic        e_req;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Steps 0-1 stream, 2-4 stall/resume (pcsource ignored while stalled), 5 branch,
    // 7-10 jump during a slow fetch, 11 jr, 13-14 wrap at 0xFFFF_FFFC.
    vecs[0]  = '{1'b1, 2'b00, 32'h0,         1'b1, 32'h0000_0004, 32'hA5A5_0000, 32'h0000_0004, 1'b1};
    vecs[1]  = '{1'b1, 2'b00, 32'h0,         1'b1, 32'h0000_0008, 32'hA5A5_0004, 32'h0000_0008, 1'b1};
    vecs[2]  = '{1'b0, 2'b01, 32'h0000_0300, 1'b1, 32'h0000_0008, 32'hA5A5_0004, 32'h0000_0008, 1'b0};
    vecs[3]  = '{1'b0, 2'b00, 32'h0,         1'b1, 32'h0000_0008, 32'hA5A5_0004, 32'h0000_0008, 1'b0};
    vecs[4]  = '{1'b1, 2'b00, 32'h0,         1'b1, 32'h0000_000C, 32'hA5A5_0008, 32'h0000_000C, 1'b1};
    vecs[5]  = '{1'b1, 2'b01, 32'h0000_0100, 1'b1, 32'h0000_0100, 32'hA5A5_000C, 32'h0000_0010, 1'b1};
    vecs[6]  = '{1'b1, 2'b00, 32'h0,         1'b1, 32'h0000_0104, 32'hA5A5_0100, 32'h0000_0104, 1'b1};
    vecs[7]  = '{1'b1, 2'b11, 32'h0000_0200, 1'b0, 32'h0000_0104, 32'h0000_0000, 32'h0000_0104, 1'b1};
    vecs[8]  = '{1'b1, 2'b00, 32'h0,         1'b0, 32'h0000_0104, 32'h0000_0000, 32'h0000_0104, 1'b1};
    vecs[9]  = '{1'b1, 2'b00, 32'h0,         1'b0, 32'h0000_0104, 32'h0000_0000, 32'h0000_0104, 1'b1};
    vecs[10] = '{1'b1, 2'b00, 32'h0,         1'b1, 32'h0000_0200, 32'hA5A5_0104, 32'h0000_0108, 1'b1};
    vecs[11] = '{1'b1, 2'b10, 32'h0000_0040, 1'b1, 32'h0000_0040, 32'hA5A5_0200, 32'h0000_0204, 1'b1};
    vecs[12] = '{1'b1, 2'b00, 32'h0,         1'b1, 32'h0000_0044, 32'hA5A5_0040, 32'h0000_0044, 1'b1};
    vecs[13] = '{1'b1, 2'b11, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'hA5A5_0044, 32'h0000_0048, 1'b1};
    vecs[14] = '{1'b1, 2'b00, 32'h0,         1'b1, 32'h0000_0000, 32'h5A5A_FFFC, 32'h0000_0000, 1'b1};

    resetn     = 1'b0;
    wpcir      = 1'b1;
    pcsource   = 2'b00;
    bpc        = 32'h0000_0300;
    jpc        = 32'h0000_0400;
    ra         = 32'h0000_0500;
    imem_ready = 1'b1;
    #12;
    check("rst_pc",   pc,   32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_dpc4", dpc4, 32'h0);
`ifdef IF_BUBBLE_CNT_EN
    check("rst_bubble_cnt", bubble_cnt, 32'h0);
`endif
    #8;
    resetn = 1'b1;
    #1;
    check("rst_req", {31'h0, imem_req}, 32'h1);

    for (int i = 0; i < NV; i++) begin
      wpcir      = vecs[i].wpcir;
      pcsource   = vecs[i].ps;
      imem_ready = vecs[i].ready;
      bpc        = 32'h0000_0300;
      jpc        = 32'h0000_0400;
      ra         = 32'h0000_0500;
      case (vecs[i].ps)
        2'b01:   bpc = vecs[i].tgt;
        2'b10:   ra  = vecs[i].tgt;
        2'b11:   jpc = vecs[i].tgt;
        default: ;
      endcase
      step();
      check($sformatf("v%0d_pc", i),   pc,        vecs[i].e_pc);
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_pc);
      check($sformatf("v%0d_inst", i), inst,      vecs[i].e_inst);
      check($sformatf("v%0d_dpc4", i), dpc4,      vecs[i].e_dpc4);
      check($sformatf("v%0d_req", i),  {31'h0, imem_req}, {31'h0, vecs[i].e_req});
`ifdef IF_BUBBLE_CNT_EN
      if (i == 10) check("bubble_cnt_after_slow_fetch", bubble_cnt, 32'd3);
`endif
    end

    // Asynchronous reset while a fetch is outstanding.
    pcsource   = 2'b00;
    wpcir      = 1'b1;
    imem_ready = 1'b1;
    step();
    check("pre_rst_inst", inst, 32'hA5A5_0000);
    check("pre_rst_pc",   pc,   32'h0000_0004);
    imem_ready = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_pc",   pc,   32'h0);
    check("async_rst_inst", inst, 32'h0);
    check("async_rst_dpc4", dpc4, 32'h0);
    check("async_rst_req",  {31'h0, imem_req}, 32'h1);
    #3;
    resetn     = 1'b1;
    imem_ready = 1'b1;
    #1;
    check("post_rst_addr", imem_addr, 32'h0);
    step();
    check("post_rst_inst", inst, 32'hA5A5_0000);
    check("post_rst_dpc4", dpc4, 32'h0000_0004);
    check("post_rst_pc",   pc,   32'h0000_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
